// File: rtl/id_regfile_sb_pkg.sv
// Shared constants for the ID-stage register file and its scoreboard.
//   DATA_W_DEF   : default register width in bits
//   ADDR_W_DEF   : default register address width
//   REGFILE_SIZE : register count for the default address width
//   ZERO_REG_IDX : index of the hardwired zero register
package id_regfile_sb_pkg;

  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned ADDR_W_DEF   = 5;
  localparam int unsigned REGFILE_SIZE = 1 << ADDR_W_DEF;
  localparam int unsigned ZERO_REG_IDX = 0;

endpackage

// File: rtl/id_scoreboard.sv
// Busy-bit scoreboard for in-flight destination writes.
//   CLK, RST   : clock (rising edge), asynchronous active-high reset
//   issue_en   : an instruction leaves ID and will write issue_adr
//   issue_adr  : destination of the issuing instruction
//   wb_en      : writeback strobe
//   wb_adr     : writeback address
//   flush      : squash all in-flight writes
//   busy       : one pending-write bit per register
//   issue_rdy  : issue_adr is free, or is being written back this cycle
//   err_waw    : sticky flag, an issue was accepted while issue_rdy was low
module id_scoreboard
  import id_regfile_sb_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned DEPTH   = 1 << ADDR_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_adr,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_adr,
  input  logic              flush,
  output logic [DEPTH-1:0]  busy,
  output logic              issue_rdy,
  output logic              err_waw
);

  logic [DEPTH-1:0] busy_nxt;

  // Priority is encoded by assignment order: flush beats issue, issue beats wb.
  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (wb_en)    busy_nxt[wb_adr]    = 1'b0;
      if (issue_en) busy_nxt[issue_adr] = 1'b1;
    end
    if (ZERO_REG != 0) busy_nxt[ZERO_REG_IDX] = 1'b0;
  end

  assign issue_rdy = !busy[issue_adr] || (wb_en && (wb_adr == issue_adr));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy    <= '0;
      err_waw <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (issue_en && !issue_rdy && !flush) err_waw <= 1'b1;
    end
  end

endmodule

// File: rtl/id_regfile_sb.sv
// Register file with writeback bypass plus scoreboard for the MIPS ID stage.
//   CLK, RST   : clock (rising edge), asynchronous active-high reset
//   rd_adr     : NUM_RD read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data    : NUM_RD combinational read data, port k at [k*DATA_W +: DATA_W]
//   rd_busy    : read register has a pending write not bypassed this cycle
//   issue_en   : instruction leaves ID and will write issue_adr
//   issue_adr  : destination of the issuing instruction
//   issue_rdy  : issue_adr has no pending write (no WAW conflict)
//   stall      : any rd_busy, or an issue that is not ready
//   wb_en, wb_adr, wb_data : writeback port
//   flush      : squash all in-flight writes
//   err_waw    : sticky WAW-violation flag, cleared only by RST
module id_regfile_sb
  import id_regfile_sb_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned DEPTH   = 1 << ADDR_W
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_RD*ADDR_W-1:0] rd_adr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_adr,
  output logic                     issue_rdy,
  output logic                     stall,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_adr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     flush,
  output logic                     err_waw
);

  localparam logic [ADDR_W-1:0] ZADR = ADDR_W'(ZERO_REG_IDX);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              wb_writable;

  assign wb_writable = wb_en && !((ZERO_REG != 0) && (wb_adr == ZADR));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wb_writable) begin
      regs[wb_adr] <= wb_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] val;

    assign adr = rd_adr[k*ADDR_W +: ADDR_W];

    always_comb begin
      val = regs[adr];
      if ((ZERO_REG != 0) && (adr == ZADR)) val = '0;
      else if (wb_writable && (wb_adr == adr)) val = wb_data;
    end

    assign rd_data[k*DATA_W +: DATA_W] = val;
    assign rd_busy[k] = busy[adr] && !(wb_en && (wb_adr == adr));
  end

  id_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .CLK       (CLK),
    .RST       (RST),
    .issue_en  (issue_en),
    .issue_adr (issue_adr),
    .wb_en     (wb_en),
    .wb_adr    (wb_adr),
    .flush     (flush),
    .busy      (busy),
    .issue_rdy (issue_rdy),
    .err_waw   (err_waw)
  );

  assign stall = (|rd_busy) || (issue_en && !issue_rdy);

endmodule
